// File: rtl/program_sequencer.sv
// program_sequencer: host run controller owning the instruction memory of the cellular-automaton core.
// Ports: clk/rst (async active-low); cmd_* host command stream (LOAD/RUN/STEP/STOP);
// load_* instruction write stream; program_counter in, instruction/execution_enable/core_rst to the core;
// busy, halted and cycle_count status.
module program_sequencer #(
    parameter int PC_WIDTH = 12,
    parameter int INSTR_WIDTH = 16,
    parameter logic [INSTR_WIDTH-1:0] HALT_WORD = 16'hFFFF,
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD = 16'h0000,
    parameter int CYCLE_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [PC_WIDTH-1:0]    cmd_arg,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [INSTR_WIDTH-1:0] load_data,
    input  logic [PC_WIDTH-1:0]    program_counter,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   execution_enable,
    output logic                   core_rst,
    output logic                   busy,
    output logic                   halted,
    output logic [CYCLE_WIDTH-1:0] cycle_count
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_STEP, S_HALTED} state_t;
    state_t state_q, state_d;
    logic [PC_WIDTH-1:0] addr_q, addr_d, cnt_q, cnt_d;
    logic [CYCLE_WIDTH-1:0] cycle_q, cycle_d;
    logic core_rst_q, core_rst_d;
    logic [INSTR_WIDTH-1:0] mem [2**PC_WIDTH];
    logic [INSTR_WIDTH-1:0] word;
    logic cmd_fire, load_fire, is_halt;

    assign cmd_ready = state_q == S_IDLE || state_q == S_HALTED || state_q == S_RUN;
    assign load_ready = state_q == S_LOAD;
    assign busy = state_q == S_LOAD || state_q == S_RUN || state_q == S_STEP;
    assign halted = state_q == S_HALTED;
    assign core_rst = core_rst_q;
    assign cycle_count = cycle_q;
    assign word = mem[program_counter];
    assign is_halt = word == HALT_WORD;
    assign execution_enable = (state_q == S_RUN || state_q == S_STEP) && !is_halt;
    assign instruction = execution_enable ? word : NOP_WORD;
    assign cmd_fire = cmd_valid && cmd_ready;
    assign load_fire = load_valid && load_ready;

    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        cnt_d = cnt_q;
        cycle_d = cycle_q + {{(CYCLE_WIDTH-1){1'b0}}, execution_enable};
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (cmd_fire && cmd_op == 2'd0) begin
                    state_d = S_LOAD;
                    addr_d = '0;
                    cnt_d = cmd_arg;
                    cycle_d = '0;
                end
                if (cmd_fire && (cmd_op == 2'd1 || cmd_op == 2'd2)) begin
                    state_d = cmd_op == 2'd1 ? S_RUN : S_STEP;
                    // A fresh start from IDLE restarts the count; resuming from HALTED keeps it.
                    cycle_d = state_q == S_IDLE ? '0 : cycle_q;
                end
            end
            S_LOAD: begin
                if (load_fire) begin
                    addr_d = addr_q + 1'b1;
                    state_d = addr_q == cnt_q ? S_IDLE : S_LOAD;
                end
            end
            // Non-STOP commands accepted in RUN are consumed without effect.
            S_RUN: state_d = (is_halt || (cmd_fire && cmd_op == 2'd3)) ? S_HALTED : S_RUN;
            S_STEP: state_d = S_HALTED;
            default: state_d = S_IDLE;
        endcase
        // Registered from the next state so the core reset lines up with the state register.
        core_rst_d = state_d == S_RUN || state_d == S_STEP || state_d == S_HALTED;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q <= '0;
            cnt_q <= '0;
            cycle_q <= '0;
            core_rst_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            cnt_q <= cnt_d;
            cycle_q <= cycle_d;
            core_rst_q <= core_rst_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load_fire) mem[addr_q] <= load_data;
    end
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: scoreboard bench for program_sequencer.
module tb_program_sequencer;
    localparam int PW = 12;
    localparam int IW = 16;
    localparam int CW = 32;
    typedef struct packed {logic [IW-1:0] ins; logic en;} exp_t;

    logic clk = 0, rst = 0;
    logic cmd_valid = 0, cmd_ready;
    logic [1:0] cmd_op = 0;
    logic [PW-1:0] cmd_arg = 0;
    logic load_valid = 0, load_ready;
    logic [IW-1:0] load_data = 0;
    logic [PW-1:0] program_counter = 0;
    logic [IW-1:0] instruction;
    logic execution_enable, core_rst, busy, halted;
    logic [CW-1:0] cycle_count;
    exp_t sb[$];
    exp_t e;
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    program_sequencer dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_arg(cmd_arg), .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
        .program_counter(program_counter), .instruction(instruction),
        .execution_enable(execution_enable), .core_rst(core_rst), .busy(busy), .halted(halted),
        .cycle_count(cycle_count)
    );

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [PW-1:0] arg);
        int t = 0;
        cmd_valid = 1; cmd_op = op; cmd_arg = arg;
        #1;
        while (!cmd_ready && t < 50) begin cyc(); t++; end
        if (t == 50) begin n_cmp++; n_err++; $display("FAIL cmd_timeout: cmd_ready=%b required 1", cmd_ready); end
        cyc();
        cmd_valid = 0;
    endtask

    task automatic feed(input logic [IW-1:0] base, input int n, input int gap_at);
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin load_valid = 0; cyc(); end
            load_valid = 1; load_data = base + IW'(i);
            #1;
            n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL load_ready_in_load: got %b required 1", load_ready); end
            n_cmp++; if (core_rst !== 1'b0) begin n_err++; $display("FAIL core_rst_in_load: got %b required 0", core_rst); end
            cyc();
        end
        load_valid = 0;
    endtask

    task automatic test_reset;
        rst = 0;
        cyc(); cyc();
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_cmd_ready: got %b required 1", cmd_ready); end
        n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL rst_load_ready: got %b required 0", load_ready); end
        n_cmp++; if (execution_enable !== 1'b0) begin n_err++; $display("FAIL rst_en: got %b required 0", execution_enable); end
        n_cmp++; if (instruction !== 16'h0000) begin n_err++; $display("FAIL rst_instr: got %h required 0000", instruction); end
        n_cmp++; if (core_rst !== 1'b0) begin n_err++; $display("FAIL rst_core_rst: got %b required 0", core_rst); end
        n_cmp++; if ({busy, halted} !== 2'b00) begin n_err++; $display("FAIL rst_busy_halted: got %b required 00", {busy, halted}); end
        n_cmp++; if (cycle_count !== 0) begin n_err++; $display("FAIL rst_cycle: got %0d required 0", cycle_count); end
        rst = 1;
        cyc();
    endtask

    task automatic test_load;
        issue(2'd0, 12'd3);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL load_busy: got %b required 1", busy); end
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin load_valid = 0; cyc(); end
            load_valid = 1; load_data = i == 3 ? 16'hFFFF : 16'hA1 + IW'(i) * 16'h11;
            #1;
            n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL load_ready: got %b required 1", load_ready); end
            n_cmp++; if (core_rst !== 1'b0) begin n_err++; $display("FAIL load_core_rst: got %b required 0", core_rst); end
            cyc();
        end
        load_valid = 0;
        #1;
        n_cmp++; if ({load_ready, busy, core_rst, cmd_ready} !== 4'b0001) begin n_err++; $display("FAIL load_done: got %b required 0001", {load_ready, busy, core_rst, cmd_ready}); end
    endtask

    task automatic test_run;
        issue(2'd1, 0);
        sb.push_back('{16'hA1, 1'b1}); sb.push_back('{16'hB2, 1'b1});
        sb.push_back('{16'hC3, 1'b1}); sb.push_back('{16'h0000, 1'b0});
        for (int pc = 0; pc < 4; pc++) begin
            program_counter = PW'(pc);
            #1;
            e = sb.pop_front();
            n_cmp++; if ({instruction, execution_enable} !== {e.ins, e.en}) begin n_err++; $display("FAIL run_pc%0d: got %h/%b required %h/%b", pc, instruction, execution_enable, e.ins, e.en); end
            n_cmp++; if (core_rst !== 1'b1) begin n_err++; $display("FAIL run_core_rst: got %b required 1", core_rst); end
            cyc();
        end
        #1;
        n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL run_halted: got %b required 1", halted); end
        n_cmp++; if (cycle_count !== 3) begin n_err++; $display("FAIL run_cycles: got %0d required 3", cycle_count); end
    endtask

    task automatic test_step;
        program_counter = 1;
        issue(2'd2, 0);
        sb.push_back('{16'hB2, 1'b1});
        #1;
        e = sb.pop_front();
        n_cmp++; if ({instruction, execution_enable} !== {e.ins, e.en}) begin n_err++; $display("FAIL step_exec: got %h/%b required %h/%b", instruction, execution_enable, e.ins, e.en); end
        n_cmp++; if ({busy, cmd_ready} !== 2'b10) begin n_err++; $display("FAIL step_flags: got %b required 10", {busy, cmd_ready}); end
        cyc();
        n_cmp++; if ({halted, execution_enable, instruction} !== {1'b1, 1'b0, 16'h0000}) begin n_err++; $display("FAIL step_after: got %b/%b/%h required 1/0/0000", halted, execution_enable, instruction); end
        n_cmp++; if (cycle_count !== 4) begin n_err++; $display("FAIL step_cycles: got %0d required 4", cycle_count); end
    endtask

    task automatic test_halt_with_stop;
        program_counter = 3;
        issue(2'd1, 0);
        cmd_valid = 1; cmd_op = 2'd3;
        #1;
        n_cmp++; if ({cmd_ready, execution_enable, instruction} !== {1'b1, 1'b0, 16'h0000}) begin n_err++; $display("FAIL hs_cycle: got %b/%b/%h required 1/0/0000", cmd_ready, execution_enable, instruction); end
        cyc();
        cmd_valid = 0;
        #1;
        n_cmp++; if ({halted, cmd_ready, busy} !== 3'b110) begin n_err++; $display("FAIL hs_after: got %b required 110", {halted, cmd_ready, busy}); end
        n_cmp++; if (cycle_count !== 4) begin n_err++; $display("FAIL hs_cycles: got %0d required 4", cycle_count); end
    endtask

    task automatic test_stop;
        issue(2'd0, 12'd15);
        feed(16'h1000, 16, -1);
        #1;
        n_cmp++; if ({busy, halted, cycle_count} !== {2'b00, 32'd0}) begin n_err++; $display("FAIL stop_idle: got %b/%0d required 00/0", {busy, halted}, cycle_count); end
        issue(2'd1, 0);
        for (int c = 0; c <= 10; c++) begin
            program_counter = PW'(c);
            sb.push_back('{16'h1000 + IW'(c), 1'b1});
            cmd_valid = c == 5 || c == 10; cmd_op = c == 10 ? 2'd3 : 2'd1;
            #1;
            e = sb.pop_front();
            n_cmp++; if ({instruction, execution_enable} !== {e.ins, e.en}) begin n_err++; $display("FAIL stop_c%0d: got %h/%b required %h/%b", c, instruction, execution_enable, e.ins, e.en); end
            n_cmp++; if ({halted, cmd_ready} !== 2'b01) begin n_err++; $display("FAIL stop_state_c%0d: got %b required 01", c, {halted, cmd_ready}); end
            cyc();
            cmd_valid = 0;
        end
        #1;
        n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL stop_halted: got %b required 1", halted); end
        n_cmp++; if (cycle_count !== 11) begin n_err++; $display("FAIL stop_cycles: got %0d required 11", cycle_count); end
    endtask

    task automatic test_reset_mid_load;
        issue(2'd0, 12'd3);
        feed(16'h5A00, 2, -1);
        rst = 0;
        #1;
        n_cmp++; if ({load_ready, busy, core_rst, cmd_ready} !== 4'b0001) begin n_err++; $display("FAIL rml_state: got %b required 0001", {load_ready, busy, core_rst, cmd_ready}); end
        n_cmp++; if (cycle_count !== 0) begin n_err++; $display("FAIL rml_cycles: got %0d required 0", cycle_count); end
        cyc();
        rst = 1;
        cyc();
        for (int pc = 1; pc >= 0; pc--) begin
            program_counter = PW'(pc);
            sb.push_back('{16'h5A00 + IW'(pc), 1'b1});
            issue(2'd2, 0);
            #1;
            e = sb.pop_front();
            n_cmp++; if ({instruction, execution_enable} !== {e.ins, e.en}) begin n_err++; $display("FAIL rml_kept%0d: got %h/%b required %h/%b", pc, instruction, execution_enable, e.ins, e.en); end
            cyc();
        end
        n_cmp++; if (cycle_count !== 2) begin n_err++; $display("FAIL rml_step_cycles: got %0d required 2", cycle_count); end
        issue(2'd0, 12'd0);
        feed(16'h7E00, 1, -1);
        program_counter = 0;
        sb.push_back('{16'h7E00, 1'b1});
        issue(2'd2, 0);
        #1;
        e = sb.pop_front();
        n_cmp++; if ({instruction, execution_enable} !== {e.ins, e.en}) begin n_err++; $display("FAIL rml_reload: got %h/%b required %h/%b", instruction, execution_enable, e.ins, e.en); end
        cyc();
        n_cmp++; if ({halted, cycle_count} !== {1'b1, 32'd1}) begin n_err++; $display("FAIL rml_final: got %b/%0d required 1/1", halted, cycle_count); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_run();
        test_step();
        test_halt_with_stop();
        test_stop();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Host-facing run controller for the cellular-automaton core (sync_control plus multiprocessor).
- Owns the 4096x16 instruction memory; a host loads it over a valid/ready stream.
- Serves instruction[program_counter] to the core, drives the core's execution_enable and an active-low core reset.
- Implements the LOAD / RUN / STEP / STOP commands, halt-word detection and an executed-cycle counter.

Parameters:
- PC_WIDTH, 12, program counter / memory address width; memory depth is 2**PC_WIDTH.
- INSTR_WIDTH, 16, instruction word width.
- HALT_WORD, 16'hFFFF, fetched word that halts execution; the word itself is not executed.
- NOP_WORD, 16'h0000, value driven on instruction whenever execution_enable is 0.
- CYCLE_WIDTH, 32, width of cycle_count.

Ports:
- clk in 1: single clock, rising edge.
- rst in 1: asynchronous, active-low reset.
- cmd_valid in 1: host command valid.
- cmd_ready out 1: command accepted when cmd_valid && cmd_ready.
- cmd_op in 2: command code. 0=LOAD, 1=RUN, 2=STEP, 3=STOP.
- cmd_arg in PC_WIDTH: for LOAD, word count minus 1; ignored for other ops.
- load_valid in 1: load word valid.
- load_ready out 1: load word accepted when load_valid && load_ready.
- load_data in INSTR_WIDTH: word to write.
- program_counter in PC_WIDTH: fetch address from sync_control.
- instruction out INSTR_WIDTH: word to sync_control and multiprocessor.
- execution_enable out 1: core executes instruction this cycle.
- core_rst out 1: active-low registered reset to the core.
- busy out 1: state is LOAD, RUN or STEP.
- halted out 1: state is HALTED.
- cycle_count out CYCLE_WIDTH: number of cycles with execution_enable=1.

Behaviour:
- States: IDLE, LOAD, RUN, STEP, HALTED. Reset enters IDLE.
- Reset values: cmd_ready=1, load_ready=0, execution_enable=0, instruction=NOP_WORD, core_rst=0, busy=0, halted=0, cycle_count=0, write address=0.
- Memory contents are not reset.
- core_rst is a registered output: 0 in IDLE and LOAD, 1 in RUN, STEP and HALTED.
- Entering RUN or STEP from IDLE therefore releases the core, so it starts at PC 0. Entering from HALTED resumes at the current PC.
- cmd_ready is 1 in IDLE, HALTED and RUN, and 0 in LOAD and STEP.
- IDLE/HALTED command handling:
  - LOAD: write address=0, count=cmd_arg, cycle_count=0, next state LOAD.
  - RUN: next state RUN.
  - STEP: next state STEP.
  - STOP: no effect.
  - RUN or STEP accepted from IDLE also clears cycle_count.
- LOAD state:
  - load_ready=1.
  - Each load handshake writes mem[addr]=load_data and increments addr.
  - The handshake that writes address == count returns the state to IDLE on the next cycle.
  - load_valid gaps are allowed; there is no timeout.
- Fetch: word = mem[program_counter], combinational read. Write-before-read hazards cannot occur, because the core never executes in LOAD.
- RUN state:
  - execution_enable = (word != HALT_WORD), combinational.
  - instruction = word when execution_enable=1, otherwise NOP_WORD.
  - If word == HALT_WORD, next state is HALTED.
  - STOP accepted: the current cycle still executes if enabled, then HALTED.
  - RUN, STEP or LOAD accepted in RUN are consumed and ignored.
  - Halt word and STOP in the same cycle: go to HALTED and consume the STOP.
- STEP state: exactly one cycle with the same enable rule as RUN, then HALTED.
- cycle_count increments on every cycle with execution_enable=1 and wraps at its maximum value.
- Reset mid-LOAD or mid-RUN: immediate IDLE, core_rst=0. Already-written words are retained.
- Width rule: the write address is PC_WIDTH bits. A count of 2**PC_WIDTH-1 fills the whole memory without address wrap errors.

Test Plan:
- Reset, then LOAD cmd_arg=3 with words A1,B2,C3,FFFF (one load_valid gap) -> mem[0..3] hold those words, state returns to IDLE, load_ready=0, core_rst=0 throughout.
- RUN from IDLE, with program_counter driven by a model counter 0,1,2,3 -> instruction A1,B2,C3 with execution_enable=1, then at PC 3 instruction=0000 and execution_enable=0. Next cycle halted=1 and cycle_count=3.
- STEP from HALTED with PC=1 -> exactly one cycle with execution_enable=1 and instruction=B2, then halted=1 and cycle_count=4.
- RUN on a program with no halt word, STOP issued at cycle 10 -> the accept cycle executes, halted=1 on the next cycle, cycle_count=11. A RUN cmd issued during RUN is accepted and has no effect.
- Halt word fetched in the same cycle a STOP is accepted -> execution_enable=0 that cycle, single transition to HALTED, cmd_ready returns to 1.
- Assert rst during LOAD after 2 of 4 words, then release -> IDLE, load_ready=0, cycle_count=0, mem[0..1] retained. A subsequent LOAD overwrites from address 0.
